// File: rtl/data_port_arbiter.sv
// Arbiter for the single 32-bit core data port: host, sink-converter writes, source-converter reads.
// Bursts are locked, the host gets a starvation-forced grant, and read data is routed by issue tag.
module data_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [31:0] i_host_addr,
    input  logic [31:0] i_host_din,
    output logic        o_host_gnt,
    output logic        o_host_rvalid,
    output logic [31:0] o_host_rdata,

    input  logic        i_snk_req,
    input  logic        i_snk_last,
    input  logic [31:0] i_snk_addr,
    input  logic [31:0] i_snk_din,
    output logic        o_snk_gnt,

    input  logic        i_src_req,
    input  logic        i_src_last,
    input  logic [31:0] i_src_addr,
    output logic        o_src_gnt,
    output logic        o_src_rvalid,
    output logic [31:0] o_src_rdata,

    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_din,
    output logic        o_mem_we,
    output logic        o_mem_oe,
    input  logic [31:0] i_mem_q
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLockSnk = 2'd1,
        StLockSrc = 2'd2
    } state_e;

    localparam logic [1:0] TagNone = 2'b00;
    localparam logic [1:0] TagHost = 2'b01;
    localparam logic [1:0] TagSrc  = 2'b10;
    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

    state_e      r_state;
    logic [7:0]  r_starve_cnt;
    logic [1:0]  r_tag [READ_LATENCY];

    logic        w_force_host;
    logic        w_host_gnt;
    logic        w_snk_gnt;
    logic        w_src_gnt;
    logic [1:0]  w_issue_tag;
    logic [1:0]  w_ret_tag;

    // Forced host grant is only consulted in IDLE, so an active lock is never broken.
    always_comb begin
        w_force_host = i_host_req && (r_starve_cnt >= StarveLimit);
    end

    always_comb begin
        w_host_gnt = 1'b0;
        w_snk_gnt  = 1'b0;
        w_src_gnt  = 1'b0;
        unique case (r_state)
            StLockSnk: w_snk_gnt = i_snk_req;
            StLockSrc: w_src_gnt = i_src_req;
            default: begin
                if (w_force_host) begin
                    w_host_gnt = 1'b1;
                end else if (i_snk_req) begin
                    w_snk_gnt = 1'b1;
                end else if (i_src_req) begin
                    w_src_gnt = 1'b1;
                end else begin
                    w_host_gnt = i_host_req;
                end
            end
        endcase
    end

    always_comb begin
        o_mem_addr = 32'd0;
        o_mem_din  = 32'd0;
        o_mem_we   = 1'b0;
        o_mem_oe   = 1'b0;
        if (w_snk_gnt) begin
            o_mem_addr = i_snk_addr;
            o_mem_din  = i_snk_din;
            o_mem_we   = 1'b1;
        end else if (w_src_gnt) begin
            o_mem_addr = i_src_addr;
            o_mem_oe   = 1'b1;
        end else if (w_host_gnt) begin
            o_mem_addr = i_host_addr;
            o_mem_din  = i_host_din;
            o_mem_we   = i_host_we;
            o_mem_oe   = !i_host_we;
        end
    end

    always_comb begin
        w_issue_tag = TagNone;
        if (w_src_gnt) begin
            w_issue_tag = TagSrc;
        end else if (w_host_gnt && !i_host_we) begin
            w_issue_tag = TagHost;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_starve_cnt <= 8'd0;
        end else begin
            unique case (r_state)
                StLockSnk: begin
                    if (w_snk_gnt && i_snk_last) begin
                        r_state <= StIdle;
                    end
                end
                StLockSrc: begin
                    if (w_src_gnt && i_src_last) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    if (w_snk_gnt && !i_snk_last) begin
                        r_state <= StLockSnk;
                    end else if (w_src_gnt && !i_src_last) begin
                        r_state <= StLockSrc;
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase

            if (w_host_gnt) begin
                r_starve_cnt <= 8'd0;
            end else if (i_host_req && (r_starve_cnt != 8'hFF)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    // One slot per cycle of read latency; the oldest slot names the owner of i_mem_q.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag[i] <= TagNone;
            end
        end else begin
            r_tag[0] <= w_issue_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        w_ret_tag = r_tag[READ_LATENCY-1];
    end

    assign o_host_gnt    = w_host_gnt;
    assign o_snk_gnt     = w_snk_gnt;
    assign o_src_gnt     = w_src_gnt;
    assign o_host_rvalid = (w_ret_tag == TagHost);
    assign o_src_rvalid  = (w_ret_tag == TagSrc);
    assign o_host_rdata  = i_mem_q;
    assign o_src_rdata   = i_mem_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Bench for data_port_arbiter: directed scenarios plus random traffic, checked each cycle
// against a requester-level model (lock owner, wait count, queue of pending read returns).
module tb_data_port_arbiter;

    localparam int unsigned LAT   = 2;
    localparam int unsigned LIMIT = 4;

    localparam int NONE = 0;
    localparam int HOST = 1;
    localparam int SNK  = 2;
    localparam int SRC  = 3;

    logic        clk;
    logic        reset;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_din;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        snk_req, snk_last;
    logic [31:0] snk_addr, snk_din;
    logic        snk_gnt;
    logic        src_req, src_last;
    logic [31:0] src_addr;
    logic        src_gnt, src_rvalid;
    logic [31:0] src_rdata;
    logic [31:0] mem_addr, mem_din;
    logic        mem_we, mem_oe;
    logic [31:0] mem_q;

    data_port_arbiter #(
        .READ_LATENCY (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_host_req    (host_req),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_din    (host_din),
        .o_host_gnt    (host_gnt),
        .o_host_rvalid (host_rvalid),
        .o_host_rdata  (host_rdata),
        .i_snk_req     (snk_req),
        .i_snk_last    (snk_last),
        .i_snk_addr    (snk_addr),
        .i_snk_din     (snk_din),
        .o_snk_gnt     (snk_gnt),
        .i_src_req     (src_req),
        .i_src_last    (src_last),
        .i_src_addr    (src_addr),
        .o_src_gnt     (src_gnt),
        .o_src_rvalid  (src_rvalid),
        .o_src_rdata   (src_rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_din     (mem_din),
        .o_mem_we      (mem_we),
        .o_mem_oe      (mem_oe),
        .i_mem_q       (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int due;
        int who;
    } rd_t;
    int  m_lock   = NONE;
    int  m_starve = 0;
    int  m_cycle  = 0;
    rd_t m_rd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic hr, input logic sr, input logic rr);
        if (m_lock == SNK) return sr ? SNK : NONE;
        if (m_lock == SRC) return rr ? SRC : NONE;
        if (hr && m_starve >= int'(LIMIT)) return HOST;
        if (sr) return SNK;
        if (rr) return SRC;
        if (hr) return HOST;
        return NONE;
    endfunction

    // One clock cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(input logic rst,
                        input logic hr, input logic hwe, input logic [31:0] ha,
                        input logic [31:0] hd,
                        input logic sr, input logic sl, input logic [31:0] sa,
                        input logic [31:0] sd,
                        input logic rr, input logic rl, input logic [31:0] ra,
                        output int who);
        logic [31:0] q;
        logic [31:0] e_addr, e_din;
        logic        e_we, e_oe;
        int          ret;
        reset = rst;
        host_req = hr; host_we = hwe; host_addr = ha; host_din = hd;
        snk_req = sr; snk_last = sl; snk_addr = sa; snk_din = sd;
        src_req = rr; src_last = rl; src_addr = ra;
        q = $urandom;
        mem_q = q;
        #1;
        who = pick(hr, sr, rr);
        ret = NONE;
        if (m_rd.size() > 0 && m_rd[0].due == m_cycle) ret = m_rd[0].who;
        e_addr = 32'd0; e_din = 32'd0; e_we = 1'b0; e_oe = 1'b0;
        case (who)
            SNK:  begin e_addr = sa; e_din = sd; e_we = 1'b1; end
            SRC:  begin e_addr = ra; e_oe = 1'b1; end
            HOST: begin e_addr = ha; e_din = hd; e_we = hwe; e_oe = !hwe; end
            default: ;
        endcase
        if (!rst) begin
            chk("host_gnt", {31'd0, host_gnt}, {31'd0, who == HOST});
            chk("snk_gnt", {31'd0, snk_gnt}, {31'd0, who == SNK});
            chk("src_gnt", {31'd0, src_gnt}, {31'd0, who == SRC});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            chk("mem_oe", {31'd0, mem_oe}, {31'd0, e_oe});
            if (who == NONE || e_we) chk("mem_din", mem_din, e_din);
            chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, ret == HOST});
            chk("src_rvalid", {31'd0, src_rvalid}, {31'd0, ret == SRC});
            if (ret == HOST) chk("host_rdata", host_rdata, q);
            if (ret == SRC) chk("src_rdata", src_rdata, q);
            chk("starve_cnt", {24'd0, dut.r_starve_cnt}, 32'(m_starve));
        end
        @(posedge clk);
        if (rst) begin
            m_lock = NONE;
            m_starve = 0;
            m_rd.delete();
            who = NONE;
        end else begin
            if (ret != NONE) void'(m_rd.pop_front());
            if (who == SNK) m_lock = sl ? NONE : SNK;
            if (who == SRC) m_lock = rl ? NONE : SRC;
            if (who == HOST) m_starve = 0;
            else if (hr && m_starve < 255) m_starve++;
            if (who == SRC || (who == HOST && !hwe)) m_rd.push_back('{m_cycle + int'(LAT), who});
        end
        m_cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    endtask

    task automatic do_reset();
        int w;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
    endtask

    initial begin
        int who, si, ri, bub;
        logic hpend;
        logic hr, hwe, sr, sl, rr, rl;
        logic [31:0] ha, hd;
        reset = 1'b1;
        host_req = 0; host_we = 0; host_addr = 0; host_din = 0;
        snk_req = 0; snk_last = 0; snk_addr = 0; snk_din = 0;
        src_req = 0; src_last = 0; src_addr = 0; mem_q = 0;
        @(negedge clk);

        // Reset state, then quiet port
        do_reset();
        idle(3);

        // All three requesting: 16-beat sink burst, 4-beat source burst, one host read
        si = 0; ri = 0; hpend = 1'b1;
        for (int c = 0; c < 26; c++) begin
            step(0, hpend, 0, 32'h10, 0,
                 si < 16, si == 15, 32'h100 + 32'(si), 32'hA000_0000 + 32'(si),
                 ri < 4, ri == 3, 32'h200 + 32'(ri), who);
            if (who == SNK) si++;
            if (who == SRC) ri++;
            if (who == HOST) hpend = 1'b0;
        end
        idle(3);

        // Sink burst with a 3-cycle bubble while host and source request
        si = 0; bub = 0;
        for (int c = 0; c < 30; c++) begin
            sr = (si < 16) && !(si == 5 && bub < 3);
            if (si == 5 && bub < 3 && c > 0) bub++;
            step(0, 1, 0, 32'h14, 0, sr, si == 15, 32'h300 + 32'(si), $urandom,
                 1, 1, 32'h240, who);
            if (who == SNK) si++;
        end
        idle(3);

        // Host read then source read on consecutive cycles
        do_reset();
        step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, who);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, who);
        idle(4);

        // Starvation: sink single-beat bursts every cycle while host waits
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(0, 1, 0, 32'h30, 0, 1, 1, 32'h400 + 32'(c), $urandom, 0, 0, 0, who);
        end
        idle(3);

        // Reset in a source lock with a read in flight
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h500, who);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h501, who);
        step(0, 1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, who);
        idle(4);

        // Host write
        step(0, 1, 1, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, who);
        idle(3);

        // Random traffic; host payload held until granted
        hr = 0; hwe = 0; ha = 0; hd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hr) begin
                hr = ($urandom_range(0, 2) == 0);
                hwe = $urandom_range(0, 1) == 1;
                ha = $urandom;
                hd = $urandom;
            end
            sr = $urandom_range(0, 2) == 0;
            sl = $urandom_range(0, 3) == 0;
            rr = $urandom_range(0, 2) == 0;
            rl = $urandom_range(0, 3) == 0;
            step($urandom_range(0, 99) == 0, hr, hwe, ha, hd, sr, sl, $urandom, $urandom,
                 rr, rl, $urandom, who);
            if (who == HOST) hr = 0;
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
